// File: rtl/prewish_mask_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : prewish_mask_sequencer
// Description : Steps through a small writable table of LED masks. A free
//               running prescaler issues a "new mask" tick every
//               2^NEWMASK_CLK_BITS clocks. Each tick strobes the table entry
//               at the current index out to a downstream blinky, and the index
//               then moves on.
//               Optional feature macro: PREWISH_SEQ_ACK_EN
//                 defined   -> STB_O is held until ACK_I is sampled high
//                 undefined -> STB_O is a single-cycle pulse, ACK_I unused
// Revision    : 1.0 - initial release
// ============================================================================
module prewish_mask_sequencer #(
  parameter int NEWMASK_CLK_BITS = 26,
  parameter int MASK_W           = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_run,
  input  logic [2:0]        i_len,
  input  logic              i_wr_en,
  input  logic [2:0]        i_wr_addr,
  input  logic [MASK_W-1:0] i_wr_data,
  output logic              STB_O,
  output logic [MASK_W-1:0] DAT_O,
  input  logic              ACK_I,
  output logic [2:0]        o_idx,
  output logic              o_miss
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_STROBE   = 2'd1,
    ST_WAIT_ACK = 2'd2
  } state_t;

  // Power-on table contents; the 8-bit patterns are fitted to MASK_W.
  function automatic logic [MASK_W-1:0] init_mask(input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = 8'hA8;
      3'd1:    b = 8'hCA;
      3'd2:    b = 8'hF0;
      3'd3:    b = 8'h0F;
      3'd4:    b = 8'hAA;
      3'd5:    b = 8'h55;
      3'd6:    b = 8'hFF;
      default: b = 8'h00;
    endcase
    return MASK_W'(b);
  endfunction

  state_t                      r_state;
  logic                        r_rel;
  logic [NEWMASK_CLK_BITS-1:0] r_presc;
  logic [MASK_W-1:0]           r_table [0:7];
  logic [2:0]                  r_idx;
  logic                        r_miss;
  logic                        w_tick;
  logic [2:0]                  w_next_idx;

  // Release qualifier: reset asserts asynchronously, but the logic only
  // starts counting once this flop has seen one clean clock after release,
  // so the first prescaler increment lands on the second edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_rel <= 1'b0;
    else          r_rel <= 1'b1;
  end

  // Prescaler: free-running while enabled, frozen while i_run is low.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)           r_presc <= '0;
    else if (r_rel && i_run) r_presc <= r_presc + NEWMASK_CLK_BITS'(1);
  end

  assign w_tick = r_rel && i_run && (r_presc == '1);

  // Next index; a shortened length that is already behind us wraps to 0.
  assign w_next_idx = (r_idx >= i_len) ? 3'd0 : r_idx + 3'd1;

  // Mask table: write lands on the next edge, so a same-cycle read sees the
  // previous contents.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 8; i++) r_table[i] <= init_mask(3'(i));
    end else if (i_wr_en) begin
      r_table[i_wr_addr] <= i_wr_data;
    end
  end

  // Handshake FSM with registered strobe/data; DAT_O is captured once on
  // entry to STROBE and otherwise left untouched.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      STB_O   <= 1'b0;
      DAT_O   <= '0;
      r_idx   <= 3'd0;
      r_miss  <= 1'b0;
    end else begin
      // A tick that arrives while a send is still in flight is lost.
      if (w_tick && (r_state != ST_IDLE)) r_miss <= 1'b1;

      case (r_state)
        ST_IDLE: begin
          if (w_tick) begin
            r_state <= ST_STROBE;
            STB_O   <= 1'b1;
            DAT_O   <= r_table[r_idx];
          end
        end
`ifdef PREWISH_SEQ_ACK_EN
        ST_STROBE: begin
          if (ACK_I) begin
            r_state <= ST_IDLE;
            STB_O   <= 1'b0;
            r_idx   <= w_next_idx;
          end else begin
            r_state <= ST_WAIT_ACK;
          end
        end
        ST_WAIT_ACK: begin
          if (ACK_I) begin
            r_state <= ST_IDLE;
            STB_O   <= 1'b0;
            r_idx   <= w_next_idx;
          end
        end
`else
        ST_STROBE: begin
          r_state <= ST_IDLE;
          STB_O   <= 1'b0;
          r_idx   <= w_next_idx;
        end
`endif
        default: begin
          r_state <= ST_IDLE;
          STB_O   <= 1'b0;
        end
      endcase
    end
  end

`ifndef PREWISH_SEQ_ACK_EN
  // Acknowledge is not part of the single-pulse handshake.
  logic w_unused_ack;
  assign w_unused_ack = ACK_I;
`endif

  assign o_idx  = r_idx;
  assign o_miss = r_miss;

endmodule
`default_nettype wire
